stream_mux_rr: RTL and testbench

- Parametrised N-channel to 1 stream multiplexer; the registered, handshaked successor of the tree-built 8x1 mux.
- Selects one of N_CH valid/ready input channels, either by an explicit select or by round-robin arbitration.
- Registers the selected word and its channel index into a single output stage.
- Sits between parallel producers (per-channel test-vector sources, event queues) and a single serial consumer in the simulator datapath.

---
 rtl/stream_mux_rr.sv | 105 ++++++++++
 tb/tb_stream_mux_rr.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 valid/ready stream multiplexer with a single
// registered output stage. A channel is chosen either by an explicit index
// (mode=0) or by round-robin arbitration starting at a rotating pointer
// (mode=1). The stage reloads in the same cycle its word is consumed, so
// throughput is one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used when mode=0 (>= N_CH selects nothing)
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered selected word
//   out_chan   index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
module stream_mux_rr #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic             w_gnt_any;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_cand;
  logic             w_xfer;

  // Output stage can take a word when empty or when its word leaves now.
  assign w_load = !r_valid || out_ready;

  // Grant selection: fixed index, or first valid channel scanning from r_ptr.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        w_cand = SEL_W'((32'(r_ptr) + i) % N_CH);
        if (!w_gnt_any && in_valid[w_cand]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end else if (32'(sel) < N_CH) begin
      w_gnt_any = in_valid[sel];
      w_gnt_idx = sel;
    end
  end

  // Ready goes only to the granted channel, never while in reset.
  always_comb begin
    in_ready = '0;
    if (w_gnt_any && w_load && !rst) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  // A grant always implies the granted channel is valid.
  assign w_xfer = w_gnt_any && w_load;

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= in_data[32'(w_gnt_idx)*WIDTH +: WIDTH];
      r_chan  <= w_gnt_idx;
      r_valid <= 1'b1;
      if (mode) begin
        r_ptr <= (32'(w_gnt_idx) == N_CH - 1) ? '0 : w_gnt_idx + SEL_W'(1);
      end
    end else if (w_load) begin
      // Consumed with nothing to replace it: data/chan keep their last value.
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed, table-driven bench for stream_mux_rr (8 x 8-bit).
// Each table row is one clock cycle: the inputs driven for that cycle, the
// expected combinational in_ready, and the expected registered outputs as
// seen during that cycle (i.e. loaded on the previous edge).
module tb_stream_mux_rr;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEL_W = 3;

  typedef struct {
    logic             rst;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [63:0]      data;
    logic [7:0]       valid;
    logic             ordy;
    logic [7:0]       exp_irdy;
    logic             exp_ov;
    logic [7:0]       exp_od;
    logic [SEL_W-1:0] exp_oc;
  } vec_t;

  logic                  clk;
  logic                  rst;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_chan;
  logic                  out_valid;
  logic                  out_ready;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // Channel i carries 8'h10+i; variants patch ch5=A5 or ch4=3C.
  localparam logic [63:0] D_BASE = 64'h17161514_13121110;
  localparam logic [63:0] D_A5   = 64'h1716A514_13121110;
  localparam logic [63:0] D_3C   = 64'h1716153C_13121110;

  stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic [2:0] s, input logic [63:0] d,
                     input logic [7:0] v, input logic ordy, input logic [7:0] irdy,
                     input logic ov, input logic [7:0] od, input logic [2:0] oc);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.data = d; t.valid = v; t.ordy = ordy;
    t.exp_irdy = irdy; t.exp_ov = ov; t.exp_od = od; t.exp_oc = oc;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic m, input logic [2:0] s, input logic [63:0] d,
                       input logic [7:0] v, input logic ordy);
    rst = r; mode = m; sel = s; in_data = d; in_valid = v; out_ready = ordy;
  endtask

  task automatic check_cycle(input string tag, input logic [7:0] irdy, input logic ov,
                             input logic [7:0] od, input logic [2:0] oc);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(irdy));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".out_data"}, 64'(out_data), 64'(od));
    check({tag, ".out_chan"}, 64'(out_chan), 64'(oc));
  endtask

  initial begin
    drive(1'b1, 1'b1, 3'd0, D_BASE, 8'hFF, 1'b1);

    // Reset held with every channel valid: nothing granted, outputs cleared.
    add(1, 1, 0, D_BASE, 8'hFF, 1, 8'h00, 0, 8'h00, 0);
    add(1, 1, 0, D_BASE, 8'hFF, 1, 8'h00, 0, 8'h00, 0);
    // Round-robin, all valid, 16 back-to-back transfers starting at ch0.
    for (int k = 0; k < 16; k++) begin
      if (k == 0) add(0, 1, 0, D_BASE, 8'hFF, 1, 8'h01, 0, 8'h00, 0);
      else add(0, 1, 0, D_BASE, 8'hFF, 1, 8'(1 << (k % 8)), 1,
               8'(8'h10 + (k - 1) % 8), 3'((k - 1) % 8));
    end
    // Fixed select ch5, then sel=7 with ch7 idle: valid drops, word held.
    add(0, 0, 5, D_A5, 8'hFF, 1, 8'h20, 1, 8'h17, 7);
    add(0, 0, 7, D_A5, 8'h7F, 1, 8'h00, 1, 8'hA5, 5);
    add(0, 0, 7, D_A5, 8'h7F, 1, 8'h00, 0, 8'hA5, 5);
    // Park the pointer at 6 via ch5, then sparse wrap: ch0, ch2, then ptr=3.
    add(0, 1, 0, D_BASE, 8'h20, 1, 8'h20, 0, 8'hA5, 5);
    add(0, 1, 0, D_BASE, 8'h05, 1, 8'h01, 1, 8'h15, 5);
    add(0, 1, 0, D_BASE, 8'h05, 1, 8'h04, 1, 8'h10, 0);
    add(0, 1, 0, D_BASE, 8'h0F, 1, 8'h08, 1, 8'h12, 2);
    // Load 3C from ch4, hold 4 cycles under backpressure, release with no bubble.
    add(0, 1, 0, D_3C, 8'h1F, 1, 8'h10, 1, 8'h13, 3);
    for (int k = 0; k < 4; k++) add(0, 1, 0, D_3C, 8'hFF, 0, 8'h00, 1, 8'h3C, 4);
    add(0, 1, 0, D_3C, 8'hFF, 1, 8'h20, 1, 8'h3C, 4);
    add(0, 1, 0, D_3C, 8'h00, 1, 8'h00, 1, 8'h15, 5);
    // Move ptr to 2, then reset while stalled: word lost, restart at ch0.
    add(0, 1, 0, D_BASE, 8'h80, 1, 8'h80, 0, 8'h15, 5);
    add(0, 1, 0, D_BASE, 8'h02, 1, 8'h02, 1, 8'h17, 7);
    add(1, 1, 0, D_BASE, 8'hFF, 0, 8'h00, 1, 8'h11, 1);
    add(0, 1, 0, D_BASE, 8'hFF, 0, 8'h01, 0, 8'h00, 0);
    add(0, 1, 0, D_BASE, 8'h00, 1, 8'h00, 1, 8'h10, 0);

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ordy);
      #1;
      check_cycle($sformatf("vec%0d", i), vecs[i].exp_irdy, vecs[i].exp_ov,
                  vecs[i].exp_od, vecs[i].exp_oc);
    end

    // Mode/sel changes during a stall leave the held word untouched.
    @(negedge clk);
    drive(0, 0, 3, D_BASE, 8'h08, 0);
    #1 check_cycle("seq_load3", 8'h08, 0, 8'h10, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, k[0], 3'(6 - k), D_BASE, 8'hFF, 0);
      #1 check_cycle($sformatf("seq_hold%0d", k), 8'h00, 1, 8'h13, 3);
    end
    @(negedge clk);
    drive(0, 0, 6, D_BASE, 8'h40, 1);
    #1 check_cycle("seq_rel", 8'h40, 1, 8'h13, 3);
    @(negedge clk);
    drive(0, 0, 6, D_BASE, 8'h00, 1);
    #1 check_cycle("seq_ch6", 8'h00, 1, 8'h16, 6);

    // Bounded wait for the stage to drain once inputs go idle.
    begin
      int n;
      n = 0;
      while (out_valid === 1'b1 && n < 5) begin
        @(negedge clk);
        n++;
      end
      check("drain_timeout", 64'(out_valid), 64'(0));
      check("drain_hold_data", 64'(out_data), 64'h16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
